// File: rtl/octree_octant_core.sv
// Octree leaf-path generator: descends MAX_DEPTH levels per point from a root box and
// streams one packed 3-bit-per-level octant path per point, then raises finish.
module octree_octant_core #(
  parameter int unsigned MAX_DEPTH  = 14,
  parameter int unsigned MAX_POINTS = 7,
  parameter int unsigned SIZE       = 16 * MAX_POINTS
) (
  input  logic                   i_clk_0,
  input  logic                   i_rst_0,
  input  logic                   i_en_0,
  input  logic [63:0]            i_far_top_right_0,
  input  logic [63:0]            i_near_bottom_left_0,
  input  logic [63:0]            i_mid_point_0,
  input  logic [31:0]            i_point_cloud_size_0,
  input  logic [SIZE-1:0]        i_points_x_0,
  input  logic [SIZE-1:0]        i_points_y_0,
  input  logic [SIZE-1:0]        i_points_z_0,
  output logic                   o_finish_0,
  output logic                   o_code_valid_0,
  output logic [7:0]             o_point_idx_0,
  output logic [3*MAX_DEPTH-1:0] o_path_0
);

  localparam int unsigned PathW = 3 * MAX_DEPTH;

  typedef enum logic [2:0] {StIdle, StLoad, StDescend, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        level_q, level_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        n_q, n_d;
  logic [PathW-1:0]  path_q, path_d;
  logic [PathW-1:0]  out_path_q, out_path_d;
  logic [7:0]        out_idx_q, out_idx_d;
  logic [SIZE-1:0]   px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic signed [15:0] lo_q [3];
  logic signed [15:0] lo_d [3];
  logic signed [15:0] hi_q [3];
  logic signed [15:0] hi_d [3];
  logic signed [15:0] root_lo_q [3];
  logic signed [15:0] root_lo_d [3];
  logic signed [15:0] root_hi_q [3];
  logic signed [15:0] root_hi_d [3];
  logic signed [15:0] mid_q [3];
  logic signed [15:0] mid_d [3];

  // Pad fields of the packed coordinate words carry no information.
  logic unused_pad;
  assign unused_pad = ^{i_far_top_right_0[15:0], i_near_bottom_left_0[15:0],
                        i_mid_point_0[15:0]};

  always_comb begin
    logic signed [15:0] p [3];
    logic signed [16:0] sum;
    logic signed [15:0] c;
    logic [2:0]         code;

    state_d    = state_q;
    level_d    = level_q;
    k_d        = k_q;
    n_d        = n_q;
    path_d     = path_q;
    out_path_d = out_path_q;
    out_idx_d  = out_idx_q;
    px_d       = px_q;
    py_d       = py_q;
    pz_d       = pz_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    root_lo_d  = root_lo_q;
    root_hi_d  = root_hi_q;
    mid_d      = mid_q;
    code       = 3'b000;
    sum        = '0;
    c          = '0;
    p[0]       = px_q[16*k_q +: 16];
    p[1]       = py_q[16*k_q +: 16];
    p[2]       = pz_q[16*k_q +: 16];

    unique case (state_q)
      StIdle: begin
        if (i_en_0) state_d = StLoad;
      end
      StLoad: begin
        for (int a = 0; a < 3; a++) begin
          root_lo_d[a] = i_near_bottom_left_0[63-16*a -: 16];
          root_hi_d[a] = i_far_top_right_0[63-16*a -: 16];
          mid_d[a]     = i_mid_point_0[63-16*a -: 16];
          lo_d[a]      = i_near_bottom_left_0[63-16*a -: 16];
          hi_d[a]      = i_far_top_right_0[63-16*a -: 16];
        end
        px_d    = i_points_x_0;
        py_d    = i_points_y_0;
        pz_d    = i_points_z_0;
        n_d     = (i_point_cloud_size_0 > 32'(MAX_POINTS)) ? 8'(MAX_POINTS)
                                                            : i_point_cloud_size_0[7:0];
        k_d     = 8'd0;
        level_d = 4'd0;
        path_d  = '0;
        state_d = (n_d == 8'd0) ? StDone : StDescend;
      end
      StDescend: begin
        for (int a = 0; a < 3; a++) begin
          // Floor of the midpoint: 17-bit sum, arithmetic shift right by one.
          sum = {lo_q[a][15], lo_q[a]} + {hi_q[a][15], hi_q[a]};
          c   = (level_q == 4'd0) ? mid_q[a] : sum[16:1];
          code[2-a] = (p[a] >= c);
          if (code[2-a]) lo_d[a] = c;
          else           hi_d[a] = c;
        end
        path_d  = PathW'({path_q, code});
        level_d = level_q + 4'd1;
        if (level_q == 4'(MAX_DEPTH - 1)) begin
          out_path_d = path_d;
          out_idx_d  = k_q;
          state_d    = StEmit;
        end
      end
      StEmit: begin
        k_d = k_q + 8'd1;
        if (k_d < n_q) begin
          lo_d    = root_lo_q;
          hi_d    = root_hi_q;
          level_d = 4'd0;
          path_d  = '0;
          state_d = StDescend;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!i_en_0) begin
          out_path_d = '0;
          out_idx_d  = 8'd0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_0) begin
    if (i_rst_0) begin
      state_q    <= StIdle;
      level_q    <= 4'd0;
      k_q        <= 8'd0;
      n_q        <= 8'd0;
      path_q     <= '0;
      out_path_q <= '0;
      out_idx_q  <= 8'd0;
      px_q       <= '0;
      py_q       <= '0;
      pz_q       <= '0;
      lo_q       <= '{default: '0};
      hi_q       <= '{default: '0};
      root_lo_q  <= '{default: '0};
      root_hi_q  <= '{default: '0};
      mid_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      k_q        <= k_d;
      n_q        <= n_d;
      path_q     <= path_d;
      out_path_q <= out_path_d;
      out_idx_q  <= out_idx_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pz_q       <= pz_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      root_lo_q  <= root_lo_d;
      root_hi_q  <= root_hi_d;
      mid_q      <= mid_d;
    end
  end

  assign o_code_valid_0 = (state_q == StEmit);
  assign o_finish_0     = (state_q == StDone);
  assign o_point_idx_0  = out_idx_q;
  assign o_path_0       = out_path_q;

endmodule

// File: tb/tb_octree_octant_core.sv
// Randomised scoreboard bench for octree_octant_core: a per-point reference descent
// predicts each strobe (index, path, cycle); a monitor pops and compares on every strobe.
module tb_octree_octant_core;

  localparam int Depth = 14;
  localparam int Pts   = 7;
  localparam int Pw    = 3 * Depth;
  localparam int Sz    = 16 * Pts;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [63:0]   far_tr, near_bl, midp;
  logic [31:0]   size;
  logic [Sz-1:0] bx, by, bz;
  logic          finish, valid;
  logic [7:0]    idx;
  logic [Pw-1:0] path;

  octree_octant_core #(.MAX_DEPTH(Depth), .MAX_POINTS(Pts), .SIZE(Sz)) dut (
    .i_clk_0(clk), .i_rst_0(rst), .i_en_0(en),
    .i_far_top_right_0(far_tr), .i_near_bottom_left_0(near_bl), .i_mid_point_0(midp),
    .i_point_cloud_size_0(size), .i_points_x_0(bx), .i_points_y_0(by), .i_points_z_0(bz),
    .o_finish_0(finish), .o_code_valid_0(valid), .o_point_idx_0(idx), .o_path_0(path)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int            pidx;
    logic [Pw-1:0] ppath;
    int            pcyc;
  } exp_t;
  exp_t sb[$];

  int root_lo[3], root_hi[3], mid[3];
  int pts[Pts][3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int floor_half(input int s);
    if (s >= 0) return s / 2;
    return -((-s + 1) / 2);
  endfunction

  // Reference descent: narrow an integer box around the point, one level at a time.
  function automatic logic [Pw-1:0] ref_path(input int pi);
    int lo[3], hi[3], c;
    logic [Pw-1:0] acc;
    int code;
    acc = '0;
    for (int a = 0; a < 3; a++) begin lo[a] = root_lo[a]; hi[a] = root_hi[a]; end
    for (int lvl = 0; lvl < Depth; lvl++) begin
      code = 0;
      for (int a = 0; a < 3; a++) begin
        c = (lvl == 0) ? mid[a] : floor_half(lo[a] + hi[a]);
        if (pts[pi][a] >= c) begin code += (4 >> a); lo[a] = c; end
        else hi[a] = c;
      end
      acc = (acc << 3) | Pw'(code);
    end
    return acc;
  endfunction

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        check("unexpected strobe", 64'(idx), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe idx", 64'(idx), 64'(e.pidx));
        check("strobe path", 64'(path), 64'(e.ppath));
        check("strobe cycle", 64'(cyc), 64'(e.pcyc));
      end
    end
  end

  task automatic drive_inputs(input int sz);
    far_tr  = {16'(root_hi[0]), 16'(root_hi[1]), 16'(root_hi[2]), 16'($urandom)};
    near_bl = {16'(root_lo[0]), 16'(root_lo[1]), 16'(root_lo[2]), 16'($urandom)};
    midp    = {16'(mid[0]), 16'(mid[1]), 16'(mid[2]), 16'($urandom)};
    for (int i = 0; i < Pts; i++) begin
      bx[16*i +: 16] = 16'(pts[i][0]);
      by[16*i +: 16] = 16'(pts[i][1]);
      bz[16*i +: 16] = 16'(pts[i][2]);
    end
    size = 32'(sz);
  endtask

  function automatic int clamp(input int sz);
    return (sz > Pts) ? Pts : sz;
  endfunction

  task automatic start_run(input int sz, output int c0);
    exp_t e;
    drive_inputs(sz);
    @(posedge clk); #1;
    c0 = cyc;
    en = 1'b1;
    for (int i = 0; i < clamp(sz); i++) begin
      e.pidx = i; e.ppath = ref_path(i); e.pcyc = c0 + 16 + 15 * i;
      sb.push_back(e);
    end
  endtask

  task automatic wait_finish(input int sz, input int c0);
    int n, fc;
    n  = clamp(sz);
    fc = (n == 0) ? c0 + 2 : c0 + 17 + 15 * (n - 1);
    for (int i = 0; i < 400 && !finish; i++) @(negedge clk);
    if (!finish) check("finish timeout", 64'(finish), 64'd1);
    else         check("finish cycle", 64'(cyc), 64'(fc));
    check("all strobes seen", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    check("finish held", 64'(finish), 64'd1);
  endtask

  task automatic end_run();
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("finish cleared", 64'(finish), 64'd0);
    check("idle path zero", 64'(path), 64'd0);
  endtask

  task automatic full_run(input int sz);
    int c0;
    start_run(sz, c0);
    wait_finish(sz, c0);
    end_run();
  endtask

  task automatic set_cloud7();
    int ref7[Pts][3] = '{'{257, -42, -155}, '{272, -45, -155}, '{-993, -154, -154},
                         '{-286, -45, -155}, '{-1325, -218, -157}, '{-302, -49, -154},
                         '{-1640, -271, -155}};
    pts = ref7;
  endtask

  task automatic set_root_spec();
    root_lo = '{-25600, -25600, -25600};
    root_hi = '{25600, 25600, 25600};
    mid     = '{-2278, 6, -63};
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  initial begin
    int c0;
    set_root_spec();
    set_cloud7();
    drive_inputs(1);
    // Reset held with en high: everything stays quiet.
    rst = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset finish", 64'(finish), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset idx", 64'(idx), 64'd0);
    check("reset path", 64'(path), 64'd0);
    en = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle finish", 64'(finish), 64'd0);

    // Single point from the reference example.
    start_run(1, c0);
    wait_finish(1, c0);
    check("single lvl0 code", 64'(path[Pw-1 -: 3]), 64'b100);
    check("single lvl1 code", 64'(path[Pw-4 -: 3]), 64'b011);
    end_run();

    // Seven-point cloud, then restart with en re-asserted.
    full_run(7);
    full_run(7);

    // Point exactly on the level-0 split point.
    pts[0] = mid;
    start_run(1, c0);
    wait_finish(1, c0);
    check("mid lvl0 code", 64'(path[Pw-1 -: 3]), 64'b111);
    end_run();

    // Point on the root minimum corner descends all-zero.
    mid = '{0, 0, 0};
    pts[0] = root_lo;
    start_run(1, c0);
    wait_finish(1, c0);
    check("root-min path", 64'(path), 64'd0);
    end_run();

    set_root_spec();
    set_cloud7();
    full_run(0);
    full_run(9);

    // Abort during point 3 descent, then a clean rerun.
    start_run(7, c0);
    while (cyc < c0 + 51) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort valid", 64'(valid), 64'd0);
    check("abort finish", 64'(finish), 64'd0);
    check("abort path", 64'(path), 64'd0);
    check("abort idx", 64'(idx), 64'd0);
    check("abort pending", 64'(sb.size()), 64'd4);
    sb.delete();
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
    full_run(7);

    // Randomised boxes, splits and clouds, including points outside the box.
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 3; a++) begin
        root_lo[a] = rnd(-30000, -1);
        root_hi[a] = rnd(0, 30000);
        mid[a]     = rnd(root_lo[a], root_hi[a]);
      end
      for (int i = 0; i < Pts; i++)
        for (int a = 0; a < 3; a++)
          pts[i][a] = (t % 3 == 0) ? rnd(-32768, 32767) : rnd(root_lo[a], root_hi[a]);
      full_run(rnd(1, 10));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
